// File: rtl/alu_flag_branch_ctrl.sv
// Execute-stage controller: issues ALU ops, captures result/flags on completion and resolves
// conditional branches against the architectural {Z,V,N} flags, interlocking behind busy ops.
module alu_flag_branch_ctrl #(
  parameter int unsigned TIMEOUT     = 16,
  parameter logic [2:0]  RESET_FLAGS = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_ctrl,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  output logic        alu_start,
  output logic [2:0]  alu_ctrl,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic [2:0]  flags_q,
  output logic        br_done,
  output logic        br_taken,
  output logic        err
);

  localparam int unsigned TimerW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpNand = 3'b010;
  localparam logic [2:0] OpXor  = 3'b011;
  localparam logic [2:0] OpInc  = 3'b100;

  localparam logic [2:0] BrNeq  = 3'b000;
  localparam logic [2:0] BrEq   = 3'b001;
  localparam logic [2:0] BrGt   = 3'b010;
  localparam logic [2:0] BrLt   = 3'b011;
  localparam logic [2:0] BrGte  = 3'b100;
  localparam logic [2:0] BrLte  = 3'b101;
  localparam logic [2:0] BrOvfl = 3'b110;

  typedef enum logic [1:0] {StIdle, StBusy, StCapture, StBranch} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              alu_start_q, alu_start_d;
  logic [2:0]        alu_ctrl_q, alu_ctrl_d;
  logic              res_valid_q, res_valid_d;
  logic [15:0]       res_data_q, res_data_d;
  logic [2:0]        flags_d;
  logic              br_done_q, br_done_d;
  logic              br_taken_q, br_taken_d;
  logic              err_q, err_d;
  logic              br_pend_q, br_pend_d;
  logic [2:0]        br_cond_q, br_cond_d;

  // Flags are packed {Z,V,N}.
  function automatic logic br_eval(input logic [2:0] cond, input logic [2:0] fl);
    logic z, v, n;
    z = fl[2];
    v = fl[1];
    n = fl[0];
    case (cond)
      BrNeq:   return !z;
      BrEq:    return z;
      BrGt:    return !z && !n;
      BrLt:    return n;
      BrGte:   return !n || z;
      BrLte:   return n || z;
      BrOvfl:  return v;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    alu_start_d = 1'b0;
    alu_ctrl_d  = alu_ctrl_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    flags_d     = flags_q;
    br_done_d   = 1'b0;
    br_taken_d  = br_taken_q;
    err_d       = err_q;
    br_pend_d   = br_pend_q;
    br_cond_d   = br_cond_q;

    case (state_q)
      StIdle: begin
        if (op_valid) begin
          state_d     = StBusy;
          alu_start_d = 1'b1;
          alu_ctrl_d  = op_ctrl;
          timer_d     = '0;
          br_pend_d   = 1'b0;
        end else if (br_valid) begin
          state_d    = StBranch;
          br_done_d  = 1'b1;
          br_taken_d = br_eval(br_cond, flags_q);
        end
      end
      StBusy: begin
        // Only the first branch seen while busy is held; later ones are dropped.
        if (br_valid && !br_pend_q) begin
          br_pend_d = 1'b1;
          br_cond_d = br_cond;
        end
        if (alu_done) begin
          state_d     = StCapture;
          res_valid_d = 1'b1;
          res_data_d  = alu_result;
          case (alu_ctrl_q)
            OpAdd, OpSub, OpInc: flags_d    = alu_flags;
            OpNand, OpXor:       flags_d[2] = alu_flags[2];
            default:             flags_d    = flags_q;
          endcase
        end else if (timer_q == TimerMax) begin
          state_d   = StIdle;
          err_d     = 1'b1;
          br_pend_d = 1'b0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StCapture: begin
        // flags_q already holds the post-update value here.
        if (br_pend_q) begin
          state_d    = StBranch;
          br_pend_d  = 1'b0;
          br_done_d  = 1'b1;
          br_taken_d = br_eval(br_cond_q, flags_q);
        end else begin
          state_d = StIdle;
        end
      end
      StBranch: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      alu_start_q <= 1'b0;
      alu_ctrl_q  <= 3'b000;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'h0000;
      flags_q     <= RESET_FLAGS;
      br_done_q   <= 1'b0;
      br_taken_q  <= 1'b0;
      err_q       <= 1'b0;
      br_pend_q   <= 1'b0;
      br_cond_q   <= 3'b000;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      alu_start_q <= alu_start_d;
      alu_ctrl_q  <= alu_ctrl_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      flags_q     <= flags_d;
      br_done_q   <= br_done_d;
      br_taken_q  <= br_taken_d;
      err_q       <= err_d;
      br_pend_q   <= br_pend_d;
      br_cond_q   <= br_cond_d;
    end
  end

  assign op_ready  = (state_q == StIdle);
  assign alu_start = alu_start_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign br_done   = br_done_q;
  assign br_taken  = br_taken_q;
  assign err       = err_q;

endmodule
